// File: rtl/reg_wb.sv
// reg_wb: eight 16-bit registers fed by a 2-entry in-order write queue.
//
// A request {N_REG_IN, DATA_IN} is queued on a rising CLK_WB edge when WB_VALID
// and WB_READY are both high. The head entry is committed to REG_<index> on a
// later edge when WB_HOLD is low. An entry is never committed on the edge that
// queues it.
//
// Ports:
//   CLK_WB     in   clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   WB_VALID   in   write request valid
//   WB_READY   out  queue not full (low while in reset)
//   N_REG_IN   in   [2:0]  destination register index
//   DATA_IN    in   [15:0] write data
//   WB_HOLD    in   freeze commits (accepts continue)
//   REG_0..7   out  [15:0] register contents
//   N_REG_OUT  out  [2:0]  index of the last committed write
//   WB_DONE    out  one-cycle pulse following each commit
//   QUEUE_CNT  out  [1:0]  queued entries, 0..2
//
// Build option: define REG_WB_ZERO_EN to make REG_0 a constant zero. Writes to
// index 0 are still queued and committed (N_REG_OUT, WB_DONE) but are dropped.

module reg_wb #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        CLK_WB,
    input  logic        RESET_N,
    input  logic        WB_VALID,
    output logic        WB_READY,
    input  logic [2:0]  N_REG_IN,
    input  logic [15:0] DATA_IN,
    input  logic        WB_HOLD,
    output logic [15:0] REG_0,
    output logic [15:0] REG_1,
    output logic [15:0] REG_2,
    output logic [15:0] REG_3,
    output logic [15:0] REG_4,
    output logic [15:0] REG_5,
    output logic [15:0] REG_6,
    output logic [15:0] REG_7,
    output logic [2:0]  N_REG_OUT,
    output logic        WB_DONE,
    output logic [1:0]  QUEUE_CNT
);

    logic [1:0]  cnt_q;
    logic [2:0]  idx_q [2];
    logic [15:0] dat_q [2];
    logic [15:0] regs_q [8];
    logic [2:0]  nout_q;
    logic        done_q;

    logic accept;
    logic commit;
    logic wr_slot1;

    always_comb begin
        WB_READY = RESET_N && (cnt_q != 2'd2);
        accept   = WB_VALID && WB_READY;
        commit   = (cnt_q != 2'd0) && !WB_HOLD;
        // New entry lands behind whatever survives this edge: slot 1 only
        // when one entry is queued and it is not leaving now.
        wr_slot1 = (cnt_q == 2'd1) && !commit;
    end

    always_ff @(posedge CLK_WB or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q  <= 2'd0;
            nout_q <= 3'd0;
            done_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                idx_q[i] <= 3'd0;
                dat_q[i] <= 16'h0000;
            end
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= RESET_VAL;
            end
`ifdef REG_WB_ZERO_EN
            regs_q[0] <= 16'h0000;
`endif
        end else begin
            if (commit) begin
`ifdef REG_WB_ZERO_EN
                if (idx_q[0] != 3'd0) begin
                    regs_q[idx_q[0]] <= dat_q[0];
                end
`else
                regs_q[idx_q[0]] <= dat_q[0];
`endif
                nout_q   <= idx_q[0];
                idx_q[0] <= idx_q[1];
                dat_q[0] <= dat_q[1];
            end
            // Placed after the shift so an accept into slot 0 overrides it.
            if (accept) begin
                if (wr_slot1) begin
                    idx_q[1] <= N_REG_IN;
                    dat_q[1] <= DATA_IN;
                end else begin
                    idx_q[0] <= N_REG_IN;
                    dat_q[0] <= DATA_IN;
                end
            end
            cnt_q  <= cnt_q + {1'b0, accept} - {1'b0, commit};
            done_q <= commit;
        end
    end

    assign REG_0     = regs_q[0];
    assign REG_1     = regs_q[1];
    assign REG_2     = regs_q[2];
    assign REG_3     = regs_q[3];
    assign REG_4     = regs_q[4];
    assign REG_5     = regs_q[5];
    assign REG_6     = regs_q[6];
    assign REG_7     = regs_q[7];
    assign N_REG_OUT = nout_q;
    assign WB_DONE   = done_q;
    assign QUEUE_CNT = cnt_q;

endmodule

// File: doc/reg_wb.md
REG_WB -- requirements
Module: reg_wb

Interface
REQ-001 The block SHALL have parameter RESET_VAL, default 16'h0000, value loaded into REG_0..REG_7 on reset.
REQ-002 The block SHALL have port CLK_WB  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port WB_VALID  input  1  write request valid.
REQ-005 The block SHALL have port WB_READY  output  1  queue can accept a request.
REQ-006 The block SHALL have port N_REG_IN  input  3  destination register index 0..7.
REQ-007 The block SHALL have port DATA_IN  input  16  write data.
REQ-008 The block SHALL have port WB_HOLD  input  1  when high, no queued write commits.
REQ-009 The block SHALL have ports REG_0..REG_7  output  16 each  register file contents.
REQ-010 The block SHALL have port N_REG_OUT  output  3  index of the most recently committed write.
REQ-011 The block SHALL have port WB_DONE  output  1  one-cycle pulse after each commit.
REQ-012 The block SHALL have port QUEUE_CNT  output  2  queued entries, 0..2.

Function
REQ-013 The block SHALL hold a 2-entry in-order write queue of {index, data} pairs.
REQ-014 WB_READY SHALL equal (QUEUE_CNT != 2) while RESET_N is high, combinational from the count.
REQ-015 A request SHALL be accepted at a rising edge where WB_VALID and WB_READY are both high; otherwise N_REG_IN/DATA_IN are ignored.
REQ-016 A commit SHALL occur at a rising edge where QUEUE_CNT > 0 and WB_HOLD is low; it writes the head entry's data into REG_<index> and pops the head.
REQ-017 At most one accept and one commit SHALL occur per edge.
REQ-018 Minimum latency SHALL be one edge: an entry accepted at edge k commits no earlier than edge k+1, and is visible on REG_n after edge k+1; no same-edge pass-through.
REQ-019 Simultaneous accept and commit SHALL leave QUEUE_CNT unchanged and preserve order.
REQ-020 With QUEUE_CNT 0, a commit SHALL NOT occur; REG_n, N_REG_OUT are unchanged and WB_DONE is low.
REQ-021 With QUEUE_CNT 2, WB_READY SHALL be low and WB_VALID has no effect.
REQ-022 Two queued writes to the same index SHALL commit in acceptance order; the later value remains.
REQ-023 On each commit edge, N_REG_OUT SHALL load the committed index and WB_DONE SHALL be high for exactly the following cycle.
REQ-024 WB_HOLD high SHALL freeze commits only; accepts continue until full.
REQ-025 Writes to one register SHALL NOT alter any other register.

Reset
REQ-026 While RESET_N is low: QUEUE_CNT = 0, queue contents discarded, REG_0..REG_7 = RESET_VAL, N_REG_OUT = 0, WB_DONE = 0, WB_READY = 0.
REQ-027 Reset assertion mid-operation SHALL take effect immediately without a clock edge; queued, uncommitted writes are lost.
REQ-028 The first accept SHALL be possible at the first rising edge after RESET_N deasserts.

Configuration
REQ-029 Macro REG_WB_ZERO_EN SHALL select register-0 behaviour.
REQ-030 With REG_WB_ZERO_EN defined: REG_0 is constant 16'h0000 regardless of RESET_VAL; writes to index 0 are accepted and committed (pop, N_REG_OUT = 0, WB_DONE pulse) but REG_0 is not changed.
REQ-031 Without REG_WB_ZERO_EN: REG_0 behaves like REG_1..REG_7.

Verification
REQ-032 Reset, then WB_VALID=1, N_REG_IN=3, DATA_IN=16'hBEEF for one edge, WB_HOLD=0 -> REG_3=16'hBEEF after the next edge, N_REG_OUT=3, WB_DONE high one cycle, QUEUE_CNT back to 0.
REQ-033 WB_HOLD=1, offer writes (1,16'h1111),(2,16'h2222),(4,16'h4444) on consecutive edges -> first two accepted, QUEUE_CNT=2, WB_READY=0, third not accepted; release hold -> REG_1 then REG_2 update on successive edges.
REQ-034 QUEUE_CNT=1 (hold released) with a new valid write on the same edge -> count stays 1, commits in order, no entry lost.
REQ-035 Queue (5,16'h0A0A) then (5,16'h0B0B) -> REG_5 ends 16'h0B0B; two WB_DONE pulses.
REQ-036 Two entries queued under WB_HOLD, pulse RESET_N low between edges -> QUEUE_CNT=0 and all REG_n=RESET_VAL immediately; no commits after release.
REQ-037 With REG_WB_ZERO_EN defined, write (0,16'hFFFF) -> REG_0 stays 16'h0000, WB_DONE pulses, N_REG_OUT=0; without the macro -> REG_0=16'hFFFF.
